// File: rtl/cpu_pkg.sv
// Shared encodings for the writeback stage: result select, load size and FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_SIZE_B  = 2'b00,
    LD_SIZE_H  = 2'b01,
    LD_SIZE_W  = 2'b10,
    LD_SIZE_W2 = 2'b11
  } ld_size_e;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

  // A retiring instruction writes the RF only if enabled, not targeting x0, and has a result.
  function automatic logic wr_qualify(input logic wb_en, input logic rd_nonzero,
                                      input logic [1:0] wb_sel);
    return wb_en && rd_nonzero && (wb_sel_e'(wb_sel) != WB_SEL_NONE);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction and sign/zero extension.
module load_extend
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half and extend it to the full word.
  always_comb begin
    byte_sel = ld_data[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? ld_data[16 +: 16] : ld_data[0 +: 16];
    ext_data = ld_data;
    case (ld_size_e'(ld_size))
      LD_SIZE_B: ext_data = {{(DATA_WIDTH-8){~ld_unsigned & byte_sel[7]}}, byte_sel};
      LD_SIZE_H: ext_data = {{(DATA_WIDTH-16){~ld_unsigned & half_sel[15]}}, half_sel};
      default:   ext_data = ld_data;
    endcase
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// WB stage: selects the retiring result, waits for load data, drives the RF write port.
module reg_writeback_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADD_WIDTH    = 5,
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADD_WIDTH-1:0]  in_rd,
  input  logic                  in_wb_en,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [1:0]            in_addr_lo,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  rf_wr_en,
  output logic [ADD_WIDTH-1:0]  rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  byp_valid,
  output logic [ADD_WIDTH-1:0]  byp_addr,
  output logic [DATA_WIDTH-1:0] byp_data,
  output logic                  pend_valid,
  output logic [ADD_WIDTH-1:0]  pend_addr,
  output logic                  err_timeout
);

  localparam int unsigned TW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(LOAD_TIMEOUT);

  wb_state_e             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADD_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADD_WIDTH-1:0]  ld_rd_q, ld_rd_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [1:0]            ld_alo_q, ld_alo_d;
  logic                  ld_qual_q, ld_qual_d;
  logic                  wr_qual;
  logic [DATA_WIDTH-1:0] ext_data;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .ld_data    (ld_data),
    .ld_size    (ld_size_q),
    .ld_unsigned(ld_uns_q),
    .addr_lo    (ld_alo_q),
    .ext_data   (ext_data)
  );

  // State, timer, load context and registered RF write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      timer_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ld_rd_q   <= '0;
      ld_size_q <= '0;
      ld_uns_q  <= 1'b0;
      ld_alo_q  <= '0;
      ld_qual_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ld_rd_q   <= ld_rd_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_alo_q  <= ld_alo_d;
      ld_qual_q <= ld_qual_d;
    end
  end

  // Next-state: accept in IDLE, complete or time out loads in WAIT_LD.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ld_rd_d   = ld_rd_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_alo_d  = ld_alo_q;
    ld_qual_d = ld_qual_q;
    wr_qual   = wr_qualify(in_wb_en, in_rd != '0, in_wb_sel);

    case (state_q)
      WB_IDLE: begin
        if (in_valid) begin
          if (wb_sel_e'(in_wb_sel) == WB_SEL_LOAD) begin
            state_d   = WB_WAIT_LD;
            timer_d   = '0;
            ld_rd_d   = in_rd;
            ld_size_d = in_ld_size;
            ld_uns_d  = in_ld_unsigned;
            ld_alo_d  = in_addr_lo;
            ld_qual_d = wr_qual;
          end else begin
            wr_en_d = wr_qual;
            if (wr_qual) begin
              wr_addr_d = in_rd;
              wr_data_d = (wb_sel_e'(in_wb_sel) == WB_SEL_LINK) ? in_pc_plus4 : in_alu_result;
            end
          end
        end
      end
      WB_WAIT_LD: begin
        if (ld_valid) begin
          wr_en_d = ld_qual_q;
          if (ld_qual_q) begin
            wr_addr_d = ld_rd_q;
            wr_data_d = ext_data;
          end
          state_d = WB_IDLE;
          timer_d = '0;
        end else if (timer_q + TW'(1) == TMAX) begin
          // Timeout fires on the LOAD_TIMEOUT-th waiting cycle without a response.
          err_d   = 1'b1;
          state_d = WB_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign in_ready    = (state_q == WB_IDLE);
  assign pend_valid  = (state_q == WB_WAIT_LD) && ld_qual_q;
  assign pend_addr   = ld_rd_q;
  assign err_timeout = err_q;
  assign rf_wr_en    = wr_en_q;
  assign rf_wr_addr  = wr_addr_q;
  assign rf_wr_data  = wr_data_q;
  assign byp_valid   = wr_en_q;
  assign byp_addr    = wr_addr_q;
  assign byp_data    = wr_data_q;

endmodule
